// File: rtl/spin_pkg.sv
// Shared types and constants for the spin ramp controller.
// SPIN_VIB_DERATE_EN enables target derating on vibration retries.
package spin_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_HOLD,
    S_RAMP_DOWN,
    S_REBALANCE,
    S_ERROR,
    S_DONE_PULSE
  } spin_state_e;

  typedef enum logic [1:0] {
    RSN_NORMAL,
    RSN_VIB,
    RSN_VIB_LIMIT
  } spin_reason_e;

  localparam int SPD_ZERO = 0;
  localparam int SPD_400  = 400;
  localparam int SPD_800  = 800;
  localparam int SPD_1200 = 1200;
  localparam int SPD_1400 = 1400;

  localparam int DERATE_STEP  = 200;
  localparam int DERATE_FLOOR = 400;

  // Never raises a target that already sits below the floor.
  function automatic int derate_target(input int t);
    if (t > DERATE_FLOOR + DERATE_STEP)
      return t - DERATE_STEP;
    else if (t > DERATE_FLOOR)
      return DERATE_FLOOR;
    else
      return t;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV tick generator.
// Synchronous clear restarts the count so the first tick lands DIV cycles later.
module tick_prescaler #(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || tick)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/spin_ramp_controller.sv
// Drum speed ramp/hold/ramp-down sequencer with vibration rebalance and retry.
// Define SPIN_VIB_DERATE_EN to lower the target by 200 rpm (floor 400) per retry.
import spin_pkg::*;

module spin_ramp_controller #(
  parameter int SPEED_W     = 11,
  parameter int STEP        = 100,
  parameter int TICK_DIV    = 5,
  parameter int MAX_SPEED   = SPD_1400,
  parameter int REBAL_SPEED = 50,
  parameter int REBAL_TICKS = 10,
  parameter int MAX_RETRIES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop_spin,
  input  logic               abort,
  input  logic               clear_error,
  input  logic [SPEED_W-1:0] target_speed,
  input  logic               vibration_sensor,
  output logic [SPEED_W-1:0] drum_motor,
  output logic               busy,
  output logic               at_speed,
  output logic               done,
  output logic               vibration_error,
  output logic [1:0]         retry_count
);

  localparam int RC_W = $clog2(REBAL_TICKS + 1);

  localparam logic [SPEED_W:0]   STEP_X  = (SPEED_W+1)'(STEP);
  localparam logic [SPEED_W-1:0] STEP_S  = SPEED_W'(STEP);
  localparam logic [SPEED_W-1:0] MAX_S   = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] REBAL_S = SPEED_W'(REBAL_SPEED);
  localparam logic [SPEED_W-1:0] ZERO_S  = SPEED_W'(SPD_ZERO);
  localparam logic [1:0]         MAX_R   = 2'(MAX_RETRIES);
  localparam logic [RC_W-1:0]    RT_LAST = RC_W'(REBAL_TICKS - 1);

  spin_state_e         state, state_n;
  spin_reason_e        reason, reason_n;
  logic [SPEED_W-1:0]  motor, motor_n;
  logic [SPEED_W-1:0]  target, target_n;
  logic [1:0]          retry, retry_n;
  logic [RC_W-1:0]     rebal_cnt, rebal_cnt_n;
  logic                tick;

  logic [SPEED_W:0]    up_sum;
  logic [SPEED_W-1:0]  up_val;
  logic [SPEED_W-1:0]  dn_val;
  logic [SPEED_W-1:0]  lim_target;
  logic [SPEED_W-1:0]  derated;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state_n != state),
    .tick  (tick)
  );

  // Wide add so the clamp sees the true sum near the top of range.
  assign up_sum     = {1'b0, motor} + STEP_X;
  assign up_val     = (up_sum >= {1'b0, target}) ? target : up_sum[SPEED_W-1:0];
  assign dn_val     = (motor > STEP_S) ? motor - STEP_S : ZERO_S;
  assign lim_target = (target_speed > MAX_S) ? MAX_S : target_speed;

`ifdef SPIN_VIB_DERATE_EN
  assign derated = SPEED_W'(derate_target(int'(target)));
`else
  assign derated = target;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      reason    <= RSN_NORMAL;
      motor     <= '0;
      target    <= '0;
      retry     <= '0;
      rebal_cnt <= '0;
    end else begin
      state     <= state_n;
      reason    <= reason_n;
      motor     <= motor_n;
      target    <= target_n;
      retry     <= retry_n;
      rebal_cnt <= rebal_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    reason_n    = reason;
    motor_n     = motor;
    target_n    = target;
    retry_n     = retry;
    rebal_cnt_n = rebal_cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          target_n = lim_target;
          retry_n  = '0;
          reason_n = RSN_NORMAL;
          motor_n  = '0;
          state_n  = (lim_target == '0) ? S_DONE_PULSE : S_RAMP_UP;
        end
      end
      S_RAMP_UP, S_HOLD: begin
        if (abort) begin
          reason_n = RSN_NORMAL;
          state_n  = S_RAMP_DOWN;
        end else if (vibration_sensor) begin
          state_n = S_RAMP_DOWN;
          if (retry < MAX_R) begin
            retry_n  = retry + 2'd1;
            reason_n = RSN_VIB;
          end else begin
            reason_n = RSN_VIB_LIMIT;
          end
        end else if (state == S_HOLD) begin
          if (stop_spin) begin
            reason_n = RSN_NORMAL;
            state_n  = S_RAMP_DOWN;
          end
        end else if (tick) begin
          motor_n = up_val;
          if (up_val == target)
            state_n = S_HOLD;
        end
      end
      S_RAMP_DOWN: begin
        if (motor == '0) begin
          unique case (reason)
            RSN_VIB: begin
              motor_n     = REBAL_S;
              rebal_cnt_n = '0;
              state_n     = S_REBALANCE;
            end
            RSN_VIB_LIMIT: state_n = S_ERROR;
            default:       state_n = S_DONE_PULSE;
          endcase
        end else if (tick) begin
          motor_n = dn_val;
        end
      end
      S_REBALANCE: begin
        if (abort) begin
          motor_n  = '0;
          reason_n = RSN_NORMAL;
          state_n  = S_RAMP_DOWN;
        end else if (tick) begin
          if (rebal_cnt == RT_LAST) begin
            // Derate here so the motor never sits above the target.
            motor_n  = '0;
            target_n = derated;
            state_n  = S_RAMP_UP;
          end else begin
            rebal_cnt_n = rebal_cnt + 1'b1;
          end
        end
      end
      S_ERROR: begin
        motor_n = '0;
        if (clear_error)
          state_n = S_IDLE;
      end
      S_DONE_PULSE: state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
  end

  assign drum_motor      = motor;
  assign busy            = (state != S_IDLE) && (state != S_ERROR);
  assign at_speed        = (state == S_HOLD);
  assign done            = (state == S_DONE_PULSE);
  assign vibration_error = (state == S_ERROR);
  assign retry_count     = retry;

endmodule

// File: tb/tb_spin_ramp_controller.sv
// Scoreboard bench for spin_ramp_controller: expected output tuples
// and hold times are queued by stimulus and checked by a monitor.
module tb_spin_ramp_controller;
  import spin_pkg::*;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stop_spin = 1'b0;
  logic         abort = 1'b0;
  logic         clear_error = 1'b0;
  logic [W-1:0] target_speed = '0;
  logic         vibration_sensor = 1'b0;
  logic [W-1:0] drum_motor;
  logic         busy;
  logic         at_speed;
  logic         done;
  logic         vibration_error;
  logic [1:0]   retry_count;

  spin_ramp_controller dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stop_spin        (stop_spin),
    .abort            (abort),
    .clear_error      (clear_error),
    .target_speed     (target_speed),
    .vibration_sensor (vibration_sensor),
    .drum_motor       (drum_motor),
    .busy             (busy),
    .at_speed         (at_speed),
    .done             (done),
    .vibration_error  (vibration_error),
    .retry_count      (retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W+5:0] obs;
    int           dwell;
  } exp_t;

  exp_t         q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  bit           mon_en = 1'b0;
  bit           first = 1'b1;
  logic [W+5:0] prev;
  int           hold = 0;
  logic [W+5:0] cur;

  assign cur = {drum_motor, busy, at_speed, done, vibration_error, retry_count};

  task automatic push(input int m, input bit b, input bit a, input bit d,
                      input bit e, input int r, input int dw);
    exp_t x;
    x.obs   = {W'(m), b, a, d, e, 2'(r)};
    x.dwell = dw;
    q.push_back(x);
  endtask

  // Monitor: every change of the output tuple consumes one expectation.
  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      if (first || cur !== prev) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_change motor=%0d flags=%b retry=%0d",
                   cur[W+5:6], cur[5:2], cur[1:0]);
        end else begin
          x = q.pop_front();
          n_chk++;
          if (cur !== x.obs) begin
            n_fail++;
            $display("FAIL tuple got motor=%0d flags=%b retry=%0d want motor=%0d flags=%b retry=%0d",
                     cur[W+5:6], cur[5:2], cur[1:0],
                     x.obs[W+5:6], x.obs[5:2], x.obs[1:0]);
          end
          if (!first && x.dwell >= 0) begin
            n_chk++;
            if (hold != x.dwell) begin
              n_fail++;
              $display("FAIL dwell at motor=%0d got %0d cycles want %0d",
                       cur[W+5:6], hold, x.dwell);
            end
          end
        end
        prev  = cur;
        hold  = 1;
        first = 1'b0;
      end else begin
        hold++;
      end
    end
  end

  task automatic tickw(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout pending=%0d", q.size());
      q.delete();
    end
    tickw(3);
  endtask

  // Full ramp up to lat, hold, ramp down, done pulse, idle.
  task automatic push_normal(input int lat, input int r);
    push(0, 1, 0, 0, 0, r, -1);
    for (int s = 100; s <= lat; s += 100)
      push(s, 1, s == lat, 0, 0, r, 5);
    push(lat, 1, 0, 0, 0, r, -1);
    for (int s = lat - 100; s >= 0; s -= 100)
      push(s, 1, 0, 0, 0, r, 5);
    push(0, 1, 0, 1, 0, r, 1);
    push(0, 0, 0, 0, 0, r, 1);
  endtask

  task automatic do_start(input int tin);
    target_speed = W'(tin);
    start = 1'b1;
    tickw(1);
    start = 1'b0;
    target_speed = '0;
  endtask

  task automatic do_normal(input int tin, input int lat);
    push_normal(lat, 0);
    do_start(tin);
    tickw(5 * (lat / 100) + 3);
    stop_spin = 1'b1;
    tickw(1);
    stop_spin = 1'b0;
    wait_drain();
  endtask

  initial begin
    push(0, 0, 0, 0, 0, 0, -1);
    tickw(3);
    mon_en = 1'b1;
    tickw(2);
    reset = 1'b0;
    tickw(2);

    do_normal(SPD_400, 400);
    do_normal(2000, 1400);

    push(0, 1, 0, 1, 0, 0, -1);
    push(0, 0, 0, 0, 0, 0, 1);
    do_start(0);
    wait_drain();

    // Vibration at 500 on an 800 ramp, then rebalance and re-ramp.
    push(0, 1, 0, 0, 0, 0, -1);
    for (int s = 100; s <= 500; s += 100)
      push(s, 1, 0, 0, 0, 0, 5);
    push(500, 1, 0, 0, 0, 1, -1);
    for (int s = 400; s >= 0; s -= 100)
      push(s, 1, 0, 0, 0, 1, 5);
    push(50, 1, 0, 0, 0, 1, 1);
    push(0, 1, 0, 0, 0, 1, 50);
    for (int s = 100; s <= 800; s += 100)
      push(s, 1, s == 800, 0, 0, 1, 5);
    push(800, 1, 0, 0, 0, 1, -1);
    for (int s = 700; s >= 0; s -= 100)
      push(s, 1, 0, 0, 0, 1, 5);
    push(0, 1, 0, 1, 0, 1, 1);
    push(0, 0, 0, 0, 0, 1, 1);
    do_start(SPD_800);
    tickw(26);
    vibration_sensor = 1'b1;
    tickw(1);
    vibration_sensor = 1'b0;
    tickw(119);
    stop_spin = 1'b1;
    tickw(1);
    stop_spin = 1'b0;
    wait_drain();

    // Four vibration events end in ERROR without a done pulse.
    push(0, 1, 0, 0, 0, 0, -1);
    push(100, 1, 0, 0, 0, 0, 5);
    for (int r = 1; r <= 3; r++) begin
      push(100, 1, 0, 0, 0, r, -1);
      push(0, 1, 0, 0, 0, r, 5);
      push(50, 1, 0, 0, 0, r, 1);
      push(0, 1, 0, 0, 0, r, 50);
      push(100, 1, 0, 0, 0, r, 5);
    end
    push(0, 1, 0, 0, 0, 3, -1);
    push(0, 0, 0, 0, 1, 3, 1);
    push(0, 0, 0, 0, 0, 3, -1);
    do_start(SPD_400);
    tickw(6);
    vibration_sensor = 1'b1;
    tickw(1);
    vibration_sensor = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tickw(62);
      vibration_sensor = 1'b1;
      tickw(1);
      vibration_sensor = 1'b0;
    end
    tickw(15);
    clear_error = 1'b1;
    tickw(1);
    clear_error = 1'b0;
    wait_drain();

    // Abort wins over vibration in HOLD; start during ramp-down ignored.
    push_normal(1200, 0);
    do_start(SPD_1200);
    tickw(61);
    abort = 1'b1;
    vibration_sensor = 1'b1;
    tickw(1);
    abort = 1'b0;
    vibration_sensor = 1'b0;
    tickw(7);
    target_speed = W'(SPD_400);
    start = 1'b1;
    tickw(1);
    start = 1'b0;
    wait_drain();

`ifdef SPIN_VIB_DERATE_EN
    push(0, 1, 0, 0, 0, 0, -1);
    push(100, 1, 0, 0, 0, 0, 5);
    push(100, 1, 0, 0, 0, 1, -1);
    push(0, 1, 0, 0, 0, 1, 5);
    push(50, 1, 0, 0, 0, 1, 1);
    push(0, 1, 0, 0, 0, 1, 50);
    for (int s = 100; s <= 1200; s += 100)
      push(s, 1, s == 1200, 0, 0, 1, 5);
    push(1200, 1, 0, 0, 0, 1, -1);
    for (int s = 1100; s >= 0; s -= 100)
      push(s, 1, 0, 0, 0, 1, 5);
    push(0, 1, 0, 1, 0, 1, 1);
    push(0, 0, 0, 0, 0, 1, 1);
    do_start(SPD_1400);
    tickw(6);
    vibration_sensor = 1'b1;
    tickw(1);
    vibration_sensor = 1'b0;
    tickw(120);
    stop_spin = 1'b1;
    tickw(1);
    stop_spin = 1'b0;
    wait_drain();
`endif

    // Reset mid-ramp at 700 clears everything at once.
    push(0, 1, 0, 0, 0, 0, -1);
    for (int s = 100; s <= 700; s += 100)
      push(s, 1, 0, 0, 0, 0, 5);
    push(0, 0, 0, 0, 0, 0, -1);
    do_start(SPD_800);
    tickw(36);
    reset = 1'b1;
    tickw(1);
    reset = 1'b0;
    wait_drain();

    tickw(5);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
